fifo_sync_param: RTL and testbench

Parametrised single-clock FIFO: the next-generation buffer for the byte-stream datapath, with configurable data width and depth, selectable standard or first-word-fall-through read mode, programmable almost-full/almost-empty thresholds, and overflow/underflow error reporting. It buffers between a producer driving `wr_en` and a consumer driving `rd_en`, both in the `clk` domain.

---
 rtl/fifo_sync_param.sv | 107 ++++++++++
 tb/tb_fifo_sync_param.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through read,
// programmable almost-full/almost-empty thresholds and overflow/underflow pulses.
module fifo_sync_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = DEPTH - 4,
  parameter int AE_LEVEL   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   buf_in,
  input  logic                    wr_en,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   buf_out,
  output logic                    buf_empty,
  output logic                    buf_full,
  output logic                    buf_almost_full,
  output logic                    buf_almost_empty,
  output logic [$clog2(DEPTH):0]  fifo_counter,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          wr_acc, rd_acc;

  // Status is decoded from the registered count only.
  assign buf_empty        = (count_q == '0);
  assign buf_full         = (count_q == CW'(DEPTH));
  assign buf_almost_full  = (count_q >= CW'(AF_LEVEL));
  assign buf_almost_empty = (count_q <= CW'(AE_LEVEL));
  assign fifo_counter     = count_q;
  assign overflow         = overflow_q;
  assign underflow        = underflow_q;

  always_comb begin
    rd_acc      = rd_en & ~buf_empty;
    // A full FIFO still takes a write when a read frees the slot in the same cycle.
    wr_acc      = wr_en & (~buf_full | rd_acc);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = wr_en & ~wr_acc;
    underflow_d = rd_en & ~rd_acc;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= buf_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented combinationally; don't-care while empty.
      assign buf_out = mem[rd_ptr_q];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q, dout_d;

      always_comb begin
        dout_d = dout_q;
        if (rd_acc) dout_d = mem[rd_ptr_q];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dout_q <= '0;
        else        dout_q <= dout_d;
      end

      assign buf_out = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: a 64-deep standard-read FIFO and an
// 8-deep first-word-fall-through FIFO driven from one linear sequence.
module tb_fifo_sync_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DEPTH=64, standard read, AF=60, AE=4
  logic [7:0] a_in, a_out;
  logic       a_wr, a_rd, a_empty, a_full, a_af, a_ae, a_ov, a_un;
  logic [6:0] a_cnt;

  fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(64), .FWFT(0), .AF_LEVEL(60), .AE_LEVEL(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .buf_in(a_in), .wr_en(a_wr), .rd_en(a_rd),
    .buf_out(a_out), .buf_empty(a_empty), .buf_full(a_full),
    .buf_almost_full(a_af), .buf_almost_empty(a_ae), .fifo_counter(a_cnt),
    .overflow(a_ov), .underflow(a_un)
  );

  // Instance B: DEPTH=8, first-word-fall-through, AF=6, AE=1
  logic [7:0] b_in, b_out;
  logic       b_wr, b_rd, b_empty, b_full, b_af, b_ae, b_ov, b_un;
  logic [3:0] b_cnt;

  fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(1), .AF_LEVEL(6), .AE_LEVEL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .buf_in(b_in), .wr_en(b_wr), .rd_en(b_rd),
    .buf_out(b_out), .buf_empty(b_empty), .buf_full(b_full),
    .buf_almost_full(b_af), .buf_almost_empty(b_ae), .fifo_counter(b_cnt),
    .overflow(b_ov), .underflow(b_un)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and land 1 time unit after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] exp_out;
    logic       wr_acc, rd_acc, exp_ov, exp_un;
    int         wr_pct;

    a_in = '0; a_wr = 1'b0; a_rd = 1'b0;
    b_in = '0; b_wr = 1'b0; b_rd = 1'b0;

    // Reset state
    repeat (3) tick;
    check("a_rst_cnt", 32'(a_cnt), 0);
    check("a_rst_empty", 32'(a_empty), 1);
    check("a_rst_full", 32'(a_full), 0);
    check("a_rst_ae", 32'(a_ae), 1);
    check("a_rst_af", 32'(a_af), 0);
    check("a_rst_ov", 32'(a_ov), 0);
    check("a_rst_un", 32'(a_un), 0);
    check("a_rst_out", 32'(a_out), 0);
    check("b_rst_cnt", 32'(b_cnt), 0);
    check("b_rst_empty", 32'(b_empty), 1);
    rst_n = 1'b1;
    tick;

    // Reset mid-burst at count 10 with a non-zero buf_out
    for (int i = 0; i < 11; i++) begin
      a_wr = 1'b1; a_in = 8'h80 + 8'(i);
      tick;
    end
    a_wr = 1'b0; a_rd = 1'b1;
    tick;
    a_rd = 1'b0;
    check("a_mid_cnt", 32'(a_cnt), 10);
    check("a_mid_out", 32'(a_out), 32'h80);
    #2 rst_n = 1'b0;
    #1;
    check("a_async_cnt", 32'(a_cnt), 0);
    check("a_async_empty", 32'(a_empty), 1);
    check("a_async_out", 32'(a_out), 0);
    tick;
    rst_n = 1'b1;
    a_wr = 1'b1; a_in = 8'h55;
    tick;
    a_wr = 1'b0; a_rd = 1'b1;
    tick;
    a_rd = 1'b0;
    check("a_post_rst_data", 32'(a_out), 32'h55);
    check("a_post_rst_cnt", 32'(a_cnt), 0);

    // Fill 0x00..0x3F with threshold tracking
    for (int i = 0; i < 64; i++) begin
      a_wr = 1'b1; a_in = 8'(i);
      tick;
      check($sformatf("a_fill_cnt%0d", i + 1), 32'(a_cnt), 32'(i + 1));
      check($sformatf("a_fill_ae%0d", i + 1), 32'(a_ae), 32'((i + 1) <= 4));
      check($sformatf("a_fill_af%0d", i + 1), 32'(a_af), 32'((i + 1) >= 60));
      check($sformatf("a_fill_full%0d", i + 1), 32'(a_full), 32'((i + 1) == 64));
    end

    // 65th write overflows
    a_in = 8'hEE;
    tick;
    a_wr = 1'b0;
    check("a_ovf_pulse", 32'(a_ov), 1);
    check("a_ovf_cnt", 32'(a_cnt), 64);
    tick;
    check("a_ovf_clear", 32'(a_ov), 0);

    // Full with simultaneous write and read
    a_wr = 1'b1; a_rd = 1'b1; a_in = 8'hA5;
    tick;
    a_wr = 1'b0; a_rd = 1'b0;
    check("a_fullrw_cnt", 32'(a_cnt), 64);
    check("a_fullrw_ov", 32'(a_ov), 0);
    check("a_fullrw_un", 32'(a_un), 0);
    check("a_fullrw_out", 32'(a_out), 32'h00);

    // Drain: 0x01..0x3F then 0xA5
    for (int j = 0; j < 64; j++) begin
      a_rd = 1'b1;
      tick;
      exp_out = (j < 63) ? 8'(j + 1) : 8'hA5;
      check($sformatf("a_drain_out%0d", j), 32'(a_out), 32'(exp_out));
      check($sformatf("a_drain_cnt%0d", j), 32'(a_cnt), 32'(63 - j));
      check($sformatf("a_drain_af%0d", j), 32'(a_af), 32'((63 - j) >= 60));
      check($sformatf("a_drain_ae%0d", j), 32'(a_ae), 32'((63 - j) <= 4));
    end

    // 65th read underflows
    tick;
    a_rd = 1'b0;
    check("a_unf_pulse", 32'(a_un), 1);
    check("a_unf_cnt", 32'(a_cnt), 0);
    check("a_unf_hold", 32'(a_out), 32'hA5);
    tick;
    check("a_unf_clear", 32'(a_un), 0);

    // FWFT: empty with simultaneous write and read
    b_wr = 1'b1; b_rd = 1'b1; b_in = 8'h3C;
    tick;
    b_wr = 1'b0; b_rd = 1'b0;
    check("b_emptyrw_un", 32'(b_un), 1);
    check("b_emptyrw_cnt", 32'(b_cnt), 1);
    check("b_emptyrw_out", 32'(b_out), 32'h3C);
    check("b_emptyrw_empty", 32'(b_empty), 0);
    tick;
    check("b_emptyrw_un_clear", 32'(b_un), 0);
    check("b_emptyrw_out_hold", 32'(b_out), 32'h3C);

    // Random concurrent traffic over wrap, against a queue scoreboard
    q.push_back(8'h3C);
    for (int c = 0; c < 100; c++) begin
      wr_pct = (c < 50) ? 75 : 35;
      b_wr = ($urandom_range(0, 99) < wr_pct);
      b_rd = ($urandom_range(0, 99) < 50);
      b_in = 8'($urandom);
      rd_acc = b_rd && (q.size() > 0);
      wr_acc = b_wr && ((q.size() < 8) || rd_acc);
      exp_ov = b_wr && !wr_acc;
      exp_un = b_rd && !rd_acc;
      if (rd_acc) void'(q.pop_front());
      if (wr_acc) q.push_back(b_in);
      tick;
      check($sformatf("b_rand_cnt%0d", c), 32'(b_cnt), 32'(q.size()));
      check($sformatf("b_rand_ov%0d", c), 32'(b_ov), 32'(exp_ov));
      check($sformatf("b_rand_un%0d", c), 32'(b_un), 32'(exp_un));
      check($sformatf("b_rand_full%0d", c), 32'(b_full), 32'(q.size() == 8));
      if (q.size() > 0)
        check($sformatf("b_rand_data%0d", c), 32'(b_out), 32'(q[0]));
    end
    b_wr = 1'b0; b_rd = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
